branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
ID-stage branch hazard controller for the 5-stage MIPS32 pipeline with branch resolution moved to ID. It detects data dependencies between a BEQ/BNE in ID and producers in EX/MEM, and sequences the required stall cycles. It drives the Forward_C_ID/Forward_D_ID selects of the ID comparator mux and uses the returned Comparetor_ID to produce the taken/flush decision. It also keeps saturating branch and stall statistics counters.

Parameters:
CNT_W, 16, width of statistics counters Branch_Count and Stall_Count

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
Branch_ID  input  1  BEQ decoded in ID
Bne_ID  input  1  BNE decoded in ID; never asserted together with Branch_ID
Rs_ID  input  5  branch source register 1
Rt_ID  input  5  branch source register 2
RegWrite_EX  input  1  EX-stage instruction writes a register
MemRead_EX  input  1  EX-stage instruction is a load
Write_Reg_EX  input  5  EX-stage destination register
RegWrite_MEM  input  1  MEM-stage instruction writes a register
MemRead_MEM  input  1  MEM-stage instruction is a load
Write_Reg_MEM  input  5  MEM-stage destination register
Comparetor_ID  input  1  equality result from the ID comparator mux
Forward_C_ID  output  1  select ALU_Result_MEM for comparator operand 1
Forward_D_ID  output  1  select ALU_Result_MEM for comparator operand 2
Stall_ID  output  1  hold PC and IF/ID register
Bubble_EX  output  1  insert NOP into ID/EX
Branch_Taken_ID  output  1  PCSrc: load branch target
Flush_IF_ID  output  1  squash the instruction fetched behind a taken branch
Branch_Count  output  CNT_W  resolved branches since reset
Stall_Count  output  CNT_W  branch stall cycles since reset

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On reset the FSM goes to IDLE, stall counter = 0, Branch_Count = 0, Stall_Count = 0. All single-bit outputs are 0 in the reset cycle.
- Branch: br = Branch_ID | Bne_ID. A register r is a hazard source only if r != 0.
- Stall need per operand r (combinational, evaluated in IDLE only):
  - 2 if MemRead_EX & RegWrite_EX & Write_Reg_EX == r.
  - Otherwise 1 if RegWrite_EX & Write_Reg_EX == r (ALU result not yet in MEM).
  - Otherwise 1 if MemRead_MEM & RegWrite_MEM & Write_Reg_MEM == r (load data not ready until WB).
  - Otherwise 0.
  - need = max(need_rs, need_rt). An EX match takes priority over a MEM match for the same register.
- FSM states:
  - IDLE: if br and need > 0, assert Stall_ID and Bubble_EX this cycle, load cnt = need-1, and go to STALL if need == 2 or to RESOLVE if need == 1. If br and need == 0, resolve in this same cycle (0 added latency).
  - STALL: Stall_ID = Bubble_EX = 1, then go to RESOLVE.
  - RESOLVE: no stall. Compute forwards, resolve the branch, return to IDLE.
- Forwarding: asserted in IDLE with need == 0, or in RESOLVE. Forward_C_ID = RegWrite_MEM & ~MemRead_MEM & Write_Reg_MEM == Rs_ID & Rs_ID != 0. Forward_D_ID is the same with Rt_ID. Both are 0 in every other cycle. WB-stage producers need no forwarding (register file writes in the first half-cycle).
- Resolution cycle (the single cycle in which forwards are valid and br = 1):
  - Branch_Taken_ID = Branch_ID&Comparetor_ID | Bne_ID&~Comparetor_ID.
  - Flush_IF_ID = Branch_Taken_ID.
  - Branch_Count increments by 1.
- Stall_Count increments by 1 in every cycle with Stall_ID = 1.
- Both counters saturate at all-ones.
- Total branch latency: 1 cycle (no hazard), 2 cycles (ALU in EX or load in MEM), 3 cycles (load in EX).
- Branch_ID/Bne_ID/Rs/Rt are held by the stalled IF/ID, so they are not re-evaluated in STALL or RESOLVE. If br drops mid-sequence, the FSM still finishes the sequence but suppresses Branch_Taken_ID, Flush_IF_ID and the Branch_Count increment.
- Reset asserted mid-STALL/RESOLVE: abort, IDLE next cycle, no taken/flush emitted.
- Non-branch instructions (br = 0) in IDLE: all outputs 0, counters unchanged.

Test Plan:
- No hazard: beq $1,$2 with 5 in both registers, no EX/MEM writes -> same cycle Branch_Taken_ID = Flush_IF_ID = 1, Stall_ID = 0, Branch_Count 0->1.
- ALU in EX: add $3 in EX, beq $3,$4 in ID -> Stall_ID = Bubble_EX = 1 for 1 cycle. Next cycle Forward_C_ID = 1, Forward_D_ID = 0, branch resolves. Stall_Count = 1.
- Load in EX: lw $5 in EX, bne $0,$5 -> 2 stall cycles, then resolve with Forward_D_ID = 0 (load now in WB). With Comparetor_ID = 0: Branch_Taken_ID = 1, Stall_Count = 2.
- $zero and dual dependency: add $0 in EX, beq $0,$0 -> no stall, taken. Then lw $6 in EX with beq $6,$6 -> exactly 2 stalls (max, not sum).
- Reset mid-stall: lw $7 in EX, beq $7,$1; assert reset in the first STALL cycle -> next cycle IDLE, all outputs 0, both counters 0.
- Saturation with CNT_W = 2: 5 no-hazard branches -> Branch_Count sticks at 3.

Source files
------------

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side view of the ID-stage branch hazard controller: hazard inputs,
// comparator feedback, and the stall/forward/redirect controls it returns.
interface branch_hazard_ctrl_if;
    logic       Branch_ID;
    logic       Bne_ID;
    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       RegWrite_EX;
    logic       MemRead_EX;
    logic [4:0] Write_Reg_EX;
    logic       RegWrite_MEM;
    logic       MemRead_MEM;
    logic [4:0] Write_Reg_MEM;
    logic       Comparetor_ID;
    logic       Forward_C_ID;
    logic       Forward_D_ID;
    logic       Stall_ID;
    logic       Bubble_EX;
    logic       Branch_Taken_ID;
    logic       Flush_IF_ID;

    modport master (
        output Branch_ID, Bne_ID, Rs_ID, Rt_ID,
        output RegWrite_EX, MemRead_EX, Write_Reg_EX,
        output RegWrite_MEM, MemRead_MEM, Write_Reg_MEM,
        output Comparetor_ID,
        input  Forward_C_ID, Forward_D_ID, Stall_ID, Bubble_EX,
        input  Branch_Taken_ID, Flush_IF_ID
    );

    modport slave (
        input  Branch_ID, Bne_ID, Rs_ID, Rt_ID,
        input  RegWrite_EX, MemRead_EX, Write_Reg_EX,
        input  RegWrite_MEM, MemRead_MEM, Write_Reg_MEM,
        input  Comparetor_ID,
        output Forward_C_ID, Forward_D_ID, Stall_ID, Bubble_EX,
        output Branch_Taken_ID, Flush_IF_ID
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls a BEQ/BNE behind EX/MEM producers,
// drives the comparator forwarding selects and resolves the branch.
module branch_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_hazard_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]     Branch_Count,
    output logic [CNT_W-1:0]     Stall_Count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need_rs, need_rt, need;
    logic       br;
    logic       resolve;
    logic       fwd_c, fwd_d, stall, taken;
    logic       br_inc;

    // Stall cycles a single branch operand still needs before it can be compared.
    function automatic logic [1:0] op_need(
        input logic [4:0] r,
        input logic       rw_ex,
        input logic       mr_ex,
        input logic [4:0] wr_ex,
        input logic       rw_mem,
        input logic       mr_mem,
        input logic [4:0] wr_mem
    );
        if (r == 5'd0)                               return 2'd0;
        if (mr_ex && rw_ex && (wr_ex == r))          return 2'd2;
        if (rw_ex && (wr_ex == r))                   return 2'd1;
        if (mr_mem && rw_mem && (wr_mem == r))       return 2'd1;
        return 2'd0;
    endfunction

    assign br = bus.Branch_ID | bus.Bne_ID;

    always_comb begin
        need_rs = op_need(bus.Rs_ID, bus.RegWrite_EX, bus.MemRead_EX, bus.Write_Reg_EX,
                          bus.RegWrite_MEM, bus.MemRead_MEM, bus.Write_Reg_MEM);
        need_rt = op_need(bus.Rt_ID, bus.RegWrite_EX, bus.MemRead_EX, bus.Write_Reg_EX,
                          bus.RegWrite_MEM, bus.MemRead_MEM, bus.Write_Reg_MEM);
        need    = (need_rs > need_rt) ? need_rs : need_rt;
    end

    // Next state, stall sequencing and the resolution-cycle controls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        resolve   = 1'b0;
        fwd_c     = 1'b0;
        fwd_d     = 1'b0;
        taken     = 1'b0;
        br_inc    = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (br) begin
                        if (need != 2'd0) begin
                            stall     = 1'b1;
                            cnt_nxt   = 2'(need - 2'd1);
                            state_nxt = (need == 2'd2) ? STALL : RESOLVE;
                        end else begin
                            resolve = 1'b1;
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    if (cnt <= 2'd1) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = RESOLVE;
                    end else begin
                        cnt_nxt = 2'(cnt - 2'd1);
                    end
                end
                RESOLVE: begin
                    resolve   = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end

        if (resolve) begin
            fwd_c  = bus.RegWrite_MEM & ~bus.MemRead_MEM &
                     (bus.Write_Reg_MEM == bus.Rs_ID) & (bus.Rs_ID != 5'd0);
            fwd_d  = bus.RegWrite_MEM & ~bus.MemRead_MEM &
                     (bus.Write_Reg_MEM == bus.Rt_ID) & (bus.Rt_ID != 5'd0);
            taken  = (bus.Branch_ID & bus.Comparetor_ID) | (bus.Bne_ID & ~bus.Comparetor_ID);
            br_inc = br;
        end
    end

    assign bus.Forward_C_ID    = fwd_c;
    assign bus.Forward_D_ID    = fwd_d;
    assign bus.Stall_ID        = stall;
    assign bus.Bubble_EX       = stall;
    assign bus.Branch_Taken_ID = taken;
    assign bus.Flush_IF_ID     = taken;

    // State and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            Branch_Count <= '0;
            Stall_Count  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (br_inc && (Branch_Count != {CNT_W{1'b1}}))
                Branch_Count <= Branch_Count + CNT_W'(1);
            if (stall && (Stall_Count != {CNT_W{1'b1}}))
                Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: single-cycle vector table plus
// multi-cycle stall, reset-abort, dropped-branch and saturation sequences.
module tb_branch_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if bus ();
    branch_hazard_ctrl_if bus2 ();
    logic [15:0] bc, sc;
    logic [1:0]  bc2, sc2;

    branch_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .Branch_Count(bc), .Stall_Count(sc)
    );
    branch_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .Branch_Count(bc2), .Stall_Count(sc2)
    );

    assign bus2.Branch_ID     = bus.Branch_ID;
    assign bus2.Bne_ID        = bus.Bne_ID;
    assign bus2.Rs_ID         = bus.Rs_ID;
    assign bus2.Rt_ID         = bus.Rt_ID;
    assign bus2.RegWrite_EX   = bus.RegWrite_EX;
    assign bus2.MemRead_EX    = bus.MemRead_EX;
    assign bus2.Write_Reg_EX  = bus.Write_Reg_EX;
    assign bus2.RegWrite_MEM  = bus.RegWrite_MEM;
    assign bus2.MemRead_MEM   = bus.MemRead_MEM;
    assign bus2.Write_Reg_MEM = bus.Write_Reg_MEM;
    assign bus2.Comparetor_ID = bus.Comparetor_ID;

    typedef struct packed {
        logic       br;
        logic       bne;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rw_ex;
        logic       mr_ex;
        logic [4:0] wr_ex;
        logic       rw_mem;
        logic       mr_mem;
        logic [4:0] wr_mem;
        logic       cmp;
    } in_t;

    // exp bits: {Forward_C, Forward_D, Stall, Bubble, Taken, Flush}
    typedef struct {
        in_t        in;
        logic [5:0] exp;
        int         bc;
        int         sc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[13];

    function automatic in_t mk(input logic b, input logic n, input int rs, input int rt,
                               input logic rwe, input logic mre, input int wre,
                               input logic rwm, input logic mrm, input int wrm,
                               input logic c);
        in_t v;
        v.br = b; v.bne = n; v.rs = 5'(rs); v.rt = 5'(rt);
        v.rw_ex = rwe; v.mr_ex = mre; v.wr_ex = 5'(wre);
        v.rw_mem = rwm; v.mr_mem = mrm; v.wr_mem = 5'(wrm);
        v.cmp = c;
        return v;
    endfunction

    task automatic drive(input in_t v);
        bus.Branch_ID     = v.br;
        bus.Bne_ID        = v.bne;
        bus.Rs_ID         = v.rs;
        bus.Rt_ID         = v.rt;
        bus.RegWrite_EX   = v.rw_ex;
        bus.MemRead_EX    = v.mr_ex;
        bus.Write_Reg_EX  = v.wr_ex;
        bus.RegWrite_MEM  = v.rw_mem;
        bus.MemRead_MEM   = v.mr_mem;
        bus.Write_Reg_MEM = v.wr_mem;
        bus.Comparetor_ID = v.cmp;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.Forward_C_ID, bus.Forward_D_ID, bus.Stall_ID,
                     bus.Bubble_EX, bus.Branch_Taken_ID, bus.Flush_IF_ID});
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        drive(mk(0,0,0,0, 0,0,0, 0,0,0, 0));
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        in_t nop;
        nop = mk(0,0,0,0, 0,0,0, 0,0,0, 0);
        //                br bne rs rt  rwe mre wre  rwm mrm wrm cmp
        vecs[0]  = '{mk(0,0, 0,0,  0,0,0,  0,0,0, 0), 6'b000000, 0, 0};
        vecs[1]  = '{mk(1,0, 1,2,  0,0,0,  0,0,0, 1), 6'b000011, 1, 0};
        vecs[2]  = '{mk(1,0, 1,2,  0,0,0,  0,0,0, 0), 6'b000000, 1, 0};
        vecs[3]  = '{mk(0,1, 1,2,  0,0,0,  0,0,0, 0), 6'b000011, 1, 0};
        vecs[4]  = '{mk(1,0, 1,2,  0,0,0,  1,0,1, 1), 6'b100011, 1, 0};
        vecs[5]  = '{mk(1,0, 1,2,  0,0,0,  1,0,2, 0), 6'b010000, 1, 0};
        vecs[6]  = '{mk(1,0, 3,4,  1,0,3,  0,0,0, 1), 6'b001100, 0, 1};
        vecs[7]  = '{mk(1,0, 1,2,  0,0,0,  1,1,2, 1), 6'b001100, 0, 1};
        vecs[8]  = '{mk(1,0, 0,0,  1,0,0,  0,0,0, 1), 6'b000011, 1, 0};
        vecs[9]  = '{mk(1,0, 1,2,  1,0,5,  0,0,0, 1), 6'b000011, 1, 0};
        vecs[10] = '{mk(0,0, 5,2,  1,1,5,  0,0,0, 1), 6'b000000, 0, 0};
        vecs[11] = '{mk(1,0, 1,1,  0,0,0,  0,0,1, 1), 6'b000011, 1, 0};
        vecs[12] = '{mk(1,0, 6,6,  1,1,6,  0,0,0, 1), 6'b001100, 0, 1};

        // Reset state
        drive(nop);
        #2 check("reset_outs", outs(), 0);
        cyc();
        check("reset_bc", int'(bc), 0);
        check("reset_sc", int'(sc), 0);

        // Single-cycle table, each vector from a fresh IDLE
        for (int i = 0; i < 13; i++) begin
            reset_cycle();
            drive(vecs[i].in);
            #2 check($sformatf("vec%0d_outs", i), outs(), int'(vecs[i].exp));
            cyc();
            check($sformatf("vec%0d_bc", i), int'(bc), vecs[i].bc);
            check($sformatf("vec%0d_sc", i), int'(sc), vecs[i].sc);
        end

        // ALU in EX: add $3 ; beq $3,$4
        reset_cycle();
        drive(mk(1,0, 3,4, 1,0,3, 0,0,0, 1));
        #2 check("alu_c1", outs(), 6'b001100);
        cyc();
        drive(mk(1,0, 3,4, 0,0,0, 1,0,3, 1));
        #2 check("alu_c2", outs(), 6'b100011);
        cyc();
        check("alu_sc", int'(sc), 1);
        check("alu_bc", int'(bc), 1);
        drive(nop);
        #2 check("alu_idle", outs(), 0);
        cyc();

        // Load in EX: lw $5 ; bne $0,$5
        reset_cycle();
        drive(mk(0,1, 0,5, 1,1,5, 0,0,0, 0));
        #2 check("ld_c1", outs(), 6'b001100);
        cyc();
        drive(mk(0,1, 0,5, 0,0,0, 1,1,5, 0));
        #2 check("ld_c2", outs(), 6'b001100);
        cyc();
        drive(mk(0,1, 0,5, 0,0,0, 0,0,0, 0));
        #2 check("ld_c3", outs(), 6'b000011);
        cyc();
        check("ld_sc", int'(sc), 2);
        check("ld_bc", int'(bc), 1);

        // Dual dependency: lw $6 ; beq $6,$6 -> two stalls, not four
        reset_cycle();
        drive(mk(1,0, 6,6, 1,1,6, 0,0,0, 1));
        cyc();
        drive(mk(1,0, 6,6, 0,0,0, 1,1,6, 1));
        #2 check("dual_c2", outs(), 6'b001100);
        cyc();
        drive(mk(1,0, 6,6, 0,0,0, 0,0,0, 1));
        #2 check("dual_c3", outs(), 6'b000011);
        cyc();
        check("dual_sc", int'(sc), 2);

        // Reset in first STALL cycle: lw $7 ; beq $7,$1
        reset_cycle();
        drive(mk(1,0, 7,1, 1,1,7, 0,0,0, 1));
        cyc();
        check("rst_pre_sc", int'(sc), 1);
        reset = 1'b1;
        drive(mk(1,0, 7,1, 0,0,0, 1,1,7, 1));
        #2 check("rst_c2", outs(), 0);
        cyc();
        reset = 1'b0;
        drive(nop);
        #2 check("rst_c3", outs(), 0);
        check("rst_bc", int'(bc), 0);
        check("rst_sc", int'(sc), 0);
        cyc();

        // Branch drops during RESOLVE: forwards still shown, no redirect
        reset_cycle();
        drive(mk(1,0, 3,4, 1,0,3, 0,0,0, 1));
        cyc();
        drive(mk(0,0, 3,4, 0,0,0, 1,0,3, 1));
        #2 check("drop_c2", outs(), 6'b100000);
        cyc();
        check("drop_bc", int'(bc), 0);
        check("drop_sc", int'(sc), 1);

        // Saturation: five no-hazard branches, CNT_W=2 instance sticks at 3
        reset_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(mk(1,0, 1,2, 0,0,0, 0,0,0, 1));
            cyc();
        end
        check("sat_bc2", int'(bc2), 3);
        check("sat_bc", int'(bc), 5);
        drive(nop);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
